// File: rtl/adder_eval_pkg.sv
// rtl/adder_eval_pkg.sv - shared types, default MISR constants and MISR step for adder_result_misr
package adder_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

    // One Galois MISR step at the default 32-bit width and polynomial.
    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] data);
        return {sig[30:0], 1'b0} ^ (sig[31] ? DEFAULT_POLY : 32'h0) ^ data;
    endfunction

endpackage

// File: rtl/adder_result_misr_xor_fold.sv
// rtl/adder_result_misr_xor_fold.sv - combinational XOR fold of a wide word into OUT_W-bit chunks
module xor_fold #(
    parameter int IN_W  = 501,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  in_data,
    output logic [OUT_W-1:0] fold
);

    localparam int NCH = (IN_W + OUT_W - 1) / OUT_W;

    logic [NCH*OUT_W-1:0] padded;

    always_comb begin
        padded = '0;
        padded[IN_W-1:0] = in_data;
        fold = '0;
        for (int i = 0; i < NCH; i++) begin
            fold = fold ^ padded[i*OUT_W +: OUT_W];
        end
    end

endmodule

// File: rtl/adder_result_misr.sv
// rtl/adder_result_misr.sv - folds adder sum/carry results into a MISR signature over a fixed-length run
module adder_result_misr
    import adder_eval_pkg::*;
#(
    parameter int                   DATA_WIDTH  = 500,
    parameter int                   SIG_WIDTH   = 32,
    parameter logic [SIG_WIDTH-1:0] POLY        = DEFAULT_POLY,
    parameter logic [SIG_WIDTH-1:0] SEED        = DEFAULT_SEED,
    parameter int                   NUM_SAMPLES = 1024
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               start,
    input  logic                               in_valid,
    input  logic [DATA_WIDTH-1:0]              S,
    input  logic                               Cout,
    output logic                               busy,
    output logic                               done,
    output logic [SIG_WIDTH-1:0]               signature,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]   sample_cnt
);

    localparam int              CNT_W    = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [SIG_WIDTH-1:0] sig;
    logic [SIG_WIDTH-1:0] sig_next;
    logic [SIG_WIDTH-1:0] fold;
    logic [SIG_WIDTH-1:0] fold_q;
    logic                 fold_v;
    logic                 accept;
    logic                 arm;

    xor_fold #(
        .IN_W  (DATA_WIDTH + 1),
        .OUT_W (SIG_WIDTH)
    ) u_fold (
        .in_data ({Cout, S}),
        .fold    (fold)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        arm        = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    arm        = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (in_valid && (cnt != FULL_CNT)) begin
                    accept = 1'b1;
                    if (cnt == LAST_CNT) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // The fold register delays the MISR by one cycle, so DRAIN absorbs the last word.
    assign sig_next = {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : '0) ^ fold_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            sig    <= SEED;
            fold_q <= '0;
            fold_v <= 1'b0;
        end else begin
            state  <= state_next;
            fold_v <= accept;
            if (accept) begin
                fold_q <= fold;
            end
            if (arm) begin
                sig <= SEED;
                cnt <= '0;
            end else begin
                if (fold_v) begin
                    sig <= sig_next;
                end
                if (accept) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);
    assign signature  = sig;
    assign sample_cnt = cnt;

endmodule

// File: tb/tb_adder_result_misr.sv
// tb/tb_adder_result_misr.sv - self-checking bench for adder_result_misr
module tb_adder_result_misr;
    import adder_eval_pkg::*;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic [499:0] S;
    logic         Cout;
    logic         start_a, start_b, start_c, start_d;

    logic        a_busy, a_done;  logic [31:0] a_sig;  logic [0:0]  a_cnt;
    logic        b_busy, b_done;  logic [31:0] b_sig;  logic [0:0]  b_cnt;
    logic        c_busy, c_done;  logic [31:0] c_sig;  logic [2:0]  c_cnt;
    logic        d_busy, d_done;  logic [31:0] d_sig;  logic [10:0] d_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    adder_result_misr #(.SEED(32'hFFFFFFFF), .NUM_SAMPLES(1)) u_a (
        .clk(clk), .resetn(resetn), .start(start_a), .in_valid(in_valid), .S(S), .Cout(Cout),
        .busy(a_busy), .done(a_done), .signature(a_sig), .sample_cnt(a_cnt));
    adder_result_misr #(.SEED(32'h00000000), .NUM_SAMPLES(1)) u_b (
        .clk(clk), .resetn(resetn), .start(start_b), .in_valid(in_valid), .S(S), .Cout(Cout),
        .busy(b_busy), .done(b_done), .signature(b_sig), .sample_cnt(b_cnt));
    adder_result_misr #(.NUM_SAMPLES(4)) u_c (
        .clk(clk), .resetn(resetn), .start(start_c), .in_valid(in_valid), .S(S), .Cout(Cout),
        .busy(c_busy), .done(c_done), .signature(c_sig), .sample_cnt(c_cnt));
    adder_result_misr u_d (
        .clk(clk), .resetn(resetn), .start(start_d), .in_valid(in_valid), .S(S), .Cout(Cout),
        .busy(d_busy), .done(d_done), .signature(d_sig), .sample_cnt(d_cnt));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit i of the 501-bit word lands on signature bit i mod 32.
    function automatic logic [31:0] model_fold(input logic [500:0] w);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 501; i++) begin
            f[i % 32] = f[i % 32] ^ w[i];
        end
        return f;
    endfunction

    function automatic logic [500:0] rand_word();
        logic [511:0] t;
        for (int i = 0; i < 16; i++) begin
            t[i*32 +: 32] = $urandom;
        end
        return t[500:0];
    endfunction

    task automatic drive(input logic [500:0] w);
        S    = w[499:0];
        Cout = w[500];
    endtask

    logic [500:0] big_words [1024];
    logic [31:0]  lfsr;
    logic [31:0]  msig;
    logic [31:0]  sig1;
    logic [500:0] w;
    int           acc;

    initial begin
        resetn = 1'b0; in_valid = 1'b0; S = '0; Cout = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        tick(); tick();
        check("rst_busy", d_busy, 0);
        check("rst_done", d_done, 0);
        check("rst_sig", d_sig, 32'hFFFFFFFF);
        check("rst_cnt", d_cnt, 0);
        check("rst_sig_seed0", b_sig, 32'h0);
        resetn = 1'b1;
        tick();

        // single zero word from SEED=FFFFFFFF
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("t1_busy", a_busy, 1);
        drive('0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        check("t1_done_n1", a_done, 0);
        tick();
        check("t1_done_n2", a_done, 1);
        check("t1_sig", a_sig, 32'hFB3EE249);
        check("t1_cnt", a_cnt, 1);

        // S=1 from SEED=0
        start_b = 1'b1; tick(); start_b = 1'b0;
        drive(501'd1); in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick();
        check("t2_done", b_done, 1);
        check("t2_sig", b_sig, 32'h00000001);

        // carry only, restarted from DONE
        start_b = 1'b1; tick(); start_b = 1'b0;
        check("t3_restart_done", b_done, 0);
        w = '0; w[500] = 1'b1;
        drive(w); in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick();
        check("t3_sig", b_sig, 32'h00100000);

        // NUM_SAMPLES=4 with pre-start pulses, start+valid, gaps and a start during RUN
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(rand_word()); tick();
        end
        in_valid = 1'b0;
        check("t4_idle_cnt", c_cnt, 0);
        check("t4_idle_busy", c_busy, 0);
        drive(rand_word()); in_valid = 1'b1; start_c = 1'b1; tick(); start_c = 1'b0;
        check("t4_startvalid_cnt", c_cnt, 0);
        msig = DEFAULT_SEED;
        acc  = 0;
        for (int cyc = 0; cyc < 60 && acc < 4; cyc++) begin
            w        = rand_word();
            drive(w);
            in_valid = 1'($urandom_range(0, 1));
            start_c  = (cyc == 3);
            if (in_valid) begin
                msig = misr_step(msig, model_fold(w));
                acc++;
            end
            tick();
        end
        start_c = 1'b0;
        check("t4_accepts", acc, 4);
        in_valid = 1'b1;
        drive(rand_word()); tick();
        drive(rand_word()); tick();
        in_valid = 1'b0;
        check("t4_done", c_done, 1);
        check("t4_cnt", c_cnt, 4);
        check("t4_sig", c_sig, msig);

        // reset in the middle of a run
        start_d = 1'b1; tick(); start_d = 1'b0;
        in_valid = 1'b1;
        drive(rand_word()); tick();
        drive(rand_word()); tick();
        in_valid = 1'b0;
        check("t5_mid_cnt", d_cnt, 2);
        resetn = 1'b0; tick(); resetn = 1'b1;
        check("t5_busy", d_busy, 0);
        check("t5_done", d_done, 0);
        check("t5_sig", d_sig, 32'hFFFFFFFF);
        check("t5_cnt", d_cnt, 0);
        check("t5_c_done", c_done, 0);

        // 1024 LFSR-driven words, run twice
        lfsr = 32'h1234ABCD;
        msig = DEFAULT_SEED;
        for (int i = 0; i < 1024; i++) begin
            logic [511:0] t;
            for (int k = 0; k < 16; k++) begin
                lfsr = lfsr ^ (lfsr << 13);
                lfsr = lfsr ^ (lfsr >> 17);
                lfsr = lfsr ^ (lfsr << 5);
                t[k*32 +: 32] = lfsr;
            end
            big_words[i] = t[500:0];
            msig = misr_step(msig, model_fold(big_words[i]));
        end
        for (int r = 0; r < 2; r++) begin
            in_valid = 1'b0;
            start_d = 1'b1; tick(); start_d = 1'b0;
            check($sformatf("t6_r%0d_start_busy", r), d_busy, 1);
            check($sformatf("t6_r%0d_start_sig", r), d_sig, 32'hFFFFFFFF);
            check($sformatf("t6_r%0d_start_cnt", r), d_cnt, 0);
            for (int i = 0; i < 1024; i++) begin
                drive(big_words[i]); in_valid = 1'b1; tick();
            end
            in_valid = 1'b0;
            check($sformatf("t6_r%0d_done_n1", r), d_done, 0);
            tick();
            check($sformatf("t6_r%0d_done_n2", r), d_done, 1);
            check($sformatf("t6_r%0d_cnt", r), d_cnt, 1024);
            check($sformatf("t6_r%0d_sig", r), d_sig, msig);
            if (r == 0) begin
                sig1 = msig;
                in_valid = 1'b1;
                drive(rand_word()); tick();
                drive(rand_word()); tick();
                in_valid = 1'b0;
                check("t6_hold_sig", d_sig, sig1);
                check("t6_hold_cnt", d_cnt, 1024);
                check("t6_hold_done", d_done, 1);
            end else begin
                check("t6_repeat_sig", d_sig, sig1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
